// File: rtl/bus_pkg.sv
// bus_pkg: op encodings, sequencer states and parameter defaults for the bus sequencer.
package bus_pkg;
  localparam int BUS_W_DEF = 8;
  localparam int NUM_REGS_DEF = 4;
  typedef enum logic [1:0] {OP_MOVE, OP_LOAD_IMM, OP_READ, OP_RSVD} op_t;
  typedef enum logic [1:0] {IDLE, DRIVE, XFER, TURN} state_t;
endpackage

// File: rtl/onehot_decoder.sv
// onehot_decoder: register index to one-hot select, all-zero when the index is out of range.
module onehot_decoder #(
  parameter int N = 4
) (
  input  logic [2:0]   idx,
  output logic [N-1:0] oh
);
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign oh[i] = idx == 3'(i);
  end
endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: sequences register-to-register, immediate and read transfers over a shared tri-state bus.
module bus_sequencer
  import bus_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int BUS_W = BUS_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [1:0]          cmd_op,
  input  logic [2:0]          cmd_src,
  input  logic [2:0]          cmd_dst,
  input  logic [BUS_W-1:0]    cmd_imm,
  output logic [NUM_REGS-1:0] reg_enable,
  output logic [NUM_REGS-1:0] reg_latch,
  inout  wire  [BUS_W-1:0]    DATA,
  output logic [BUS_W-1:0]    rd_data,
  output logic                done,
  output logic                err
);
  state_t state, state_n;
  op_t op_q, op_in;
  logic [2:0] src_q, dst_q;
  logic [BUS_W-1:0] imm_q;
  logic [NUM_REGS-1:0] src_oh, dst_oh;
  logic accept, cmd_ok, src_ok, dst_ok, busy;

  onehot_decoder #(.N(NUM_REGS)) u_src_dec (.idx(src_q), .oh(src_oh));
  onehot_decoder #(.N(NUM_REGS)) u_dst_dec (.idx(dst_q), .oh(dst_oh));

  always_comb begin
    op_in = op_t'(cmd_op);
    src_ok = 32'(cmd_src) < NUM_REGS;
    dst_ok = 32'(cmd_dst) < NUM_REGS;
    cmd_ok = op_in == OP_MOVE ? src_ok && dst_ok :
             op_in == OP_LOAD_IMM ? dst_ok :
             op_in == OP_READ ? src_ok : 1'b0;
    cmd_ready = state == IDLE;
    accept = cmd_valid && cmd_ready;
    busy = state == DRIVE || state == XFER;
    state_n = state == IDLE ? (accept && cmd_ok ? DRIVE : IDLE) :
              state == DRIVE ? XFER :
              state == XFER ? TURN : IDLE;
    reg_enable = busy && op_q != OP_LOAD_IMM ? src_oh : '0;
    reg_latch = state == XFER && op_q != OP_READ ? dst_oh : '0;
    done = state == TURN;
  end

  // The sequencer owns the bus only for an immediate load; TURN leaves a dead cycle.
  assign DATA = busy && op_q == OP_LOAD_IMM ? imm_q : 'z;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op_q <= OP_MOVE;
      src_q <= '0;
      dst_q <= '0;
      imm_q <= '0;
      rd_data <= '0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      err <= accept && !cmd_ok;
      if (accept) begin
        op_q <= op_in;
        src_q <= cmd_src;
        dst_q <= cmd_dst;
        imm_q <= cmd_imm;
      end
      if (state == XFER && op_q == OP_READ) rd_data <= DATA;
    end
  end
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: table-driven and directed checks of bus_sequencer with four bus registers on DATA.
module tb_bus_sequencer;
  logic clk = 0, reset_n = 0, cmd_valid = 0, cmd_ready, done, err;
  logic [1:0] cmd_op = 0;
  logic [2:0] cmd_src = 0, cmd_dst = 0;
  logic [7:0] cmd_imm = 0, rd_data;
  logic [3:0] reg_enable, reg_latch;
  wire  [7:0] data;
  logic [7:0] r [4];
  logic [1:0] sel;
  int checks = 0, failures = 0;

  bus_sequencer #(.NUM_REGS(4), .BUS_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_imm(cmd_imm),
    .reg_enable(reg_enable), .reg_latch(reg_latch), .DATA(data),
    .rd_data(rd_data), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    sel = 2'd0;
    for (int i = 0; i < 4; i++) if (reg_enable[i]) sel = 2'(i);
  end
  assign data = reg_enable != 0 ? r[sel] : 'z;

  always @(posedge clk)
    for (int i = 0; i < 4; i++) if (reg_latch[i]) r[i] <= data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0] op;
    logic [2:0] src, dst;
    logic [7:0] imm;
    logic       ex_err;
    logic [3:0] ex_lat, ex_en;
    logic [7:0] ex_rd;
  } vec_t;

  int o_err, o_done, o_drv;
  logic [3:0] o_lat, o_en, o_lat_or, o_en_or;

  task automatic issue(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d, input logic [7:0] imm);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_op = op; cmd_src = s; cmd_dst = d; cmd_imm = imm; cmd_valid = 1;
    @(posedge clk);
    #1 cmd_valid = 0;
    o_err = 0; o_done = 0; o_drv = 0; o_lat = 0; o_en = 0; o_lat_or = 0; o_en_or = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      o_err += int'(err);
      o_done += int'(done);
      if (c == 1) begin o_lat = reg_latch; o_en = reg_enable; end
      o_lat_or |= reg_latch;
      o_en_or |= reg_enable;
      if ($countones(reg_enable) > o_drv) o_drv = $countones(reg_enable);
      if (done && reg_enable != 0) o_drv = 9;
    end
  endtask

  vec_t v [15];
  int t [3];
  logic [1:0] b_op [3];
  logic [2:0] b_src [3], b_dst [3];

  initial begin
    v[0]  = '{2'd1, 3'd0, 3'd2, 8'hA5, 1'b0, 4'b0100, 4'b0000, 8'h00};
    v[1]  = '{2'd2, 3'd2, 3'd0, 8'h00, 1'b0, 4'b0000, 4'b0100, 8'hA5};
    v[2]  = '{2'd1, 3'd0, 3'd0, 8'h3C, 1'b0, 4'b0001, 4'b0000, 8'hA5};
    v[3]  = '{2'd0, 3'd0, 3'd3, 8'h00, 1'b0, 4'b1000, 4'b0001, 8'hA5};
    v[4]  = '{2'd2, 3'd3, 3'd0, 8'h00, 1'b0, 4'b0000, 4'b1000, 8'h3C};
    v[5]  = '{2'd2, 3'd0, 3'd0, 8'h00, 1'b0, 4'b0000, 4'b0001, 8'h3C};
    v[6]  = '{2'd1, 3'd0, 3'd1, 8'h5A, 1'b0, 4'b0010, 4'b0000, 8'h3C};
    v[7]  = '{2'd0, 3'd1, 3'd1, 8'h00, 1'b0, 4'b0010, 4'b0010, 8'h3C};
    v[8]  = '{2'd2, 3'd1, 3'd0, 8'h00, 1'b0, 4'b0000, 4'b0010, 8'h5A};
    v[9]  = '{2'd3, 3'd0, 3'd1, 8'h00, 1'b1, 4'b0000, 4'b0000, 8'h5A};
    v[10] = '{2'd0, 3'd0, 3'd5, 8'h00, 1'b1, 4'b0000, 4'b0000, 8'h5A};
    v[11] = '{2'd2, 3'd7, 3'd0, 8'h00, 1'b1, 4'b0000, 4'b0000, 8'h5A};
    v[12] = '{2'd1, 3'd7, 3'd4, 8'h66, 1'b1, 4'b0000, 4'b0000, 8'h5A};
    v[13] = '{2'd1, 3'd7, 3'd3, 8'h11, 1'b0, 4'b1000, 4'b0000, 8'h5A};
    v[14] = '{2'd2, 3'd3, 3'd0, 8'h00, 1'b0, 4'b0000, 4'b1000, 8'h11};

    #3;
    chk("rst_enable", 32'(reg_enable), 0);
    chk("rst_latch", 32'(reg_latch), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_done_err", {done, err}, 0);
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("ready_after_rst", 32'(cmd_ready), 1);

    for (int i = 0; i < 15; i++) begin
      issue(v[i].op, v[i].src, v[i].dst, v[i].imm);
      chk($sformatf("v%0d_err", i), o_err, 32'(v[i].ex_err));
      chk($sformatf("v%0d_done", i), o_done, v[i].ex_err ? 0 : 1);
      chk($sformatf("v%0d_latch_xfer", i), 32'(o_lat), 32'(v[i].ex_lat));
      chk($sformatf("v%0d_enable_xfer", i), 32'(o_en), 32'(v[i].ex_en));
      chk($sformatf("v%0d_latch_any", i), 32'(o_lat_or), 32'(v[i].ex_lat));
      chk($sformatf("v%0d_enable_any", i), 32'(o_en_or), 32'(v[i].ex_en));
      chk($sformatf("v%0d_rd_data", i), 32'(rd_data), 32'(v[i].ex_rd));
      chk($sformatf("v%0d_drivers", i), 32'(o_drv <= 1), 1);
    end
    chk("r0_kept", 32'(r[0]), 32'h3C);
    chk("r1_self_move", 32'(r[1]), 32'h5A);

    // back-to-back with cmd_valid held high
    b_op = '{2'd1, 2'd0, 2'd2};
    b_src = '{3'd0, 3'd0, 3'd2};
    b_dst = '{3'd0, 3'd2, 3'd0};
    t = '{-100, -50, 0};
    begin
      int k = 0, dn = 0, mx = 0, turn_bad = 0, en = 0;
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        dn += int'(done);
        en += int'(err);
        if ($countones(reg_enable) > mx) mx = $countones(reg_enable);
        if (done && reg_enable != 0) turn_bad++;
        if (cmd_ready) begin
          if (k < 3) begin
            cmd_op = b_op[k]; cmd_src = b_src[k]; cmd_dst = b_dst[k]; cmd_imm = 8'h77;
            cmd_valid = 1; t[k] = c; k++;
          end else cmd_valid = 0;
        end
      end
      chk("b2b_gap01", t[1] - t[0], 4);
      chk("b2b_gap12", t[2] - t[1], 4);
      chk("b2b_done_count", dn, 3);
      chk("b2b_err_count", en, 0);
      chk("b2b_max_drivers", 32'(mx <= 1), 1);
      chk("b2b_turn_drivers", turn_bad, 0);
      chk("b2b_rd_data", 32'(rd_data), 32'h77);
      chk("b2b_r2", 32'(r[2]), 32'h77);
    end

    // reset during XFER of a MOVE
    issue(2'd1, 3'd0, 3'd3, 8'h99);
    chk("pre_abort_r3", 32'(r[3]), 32'h99);
    @(negedge clk);
    cmd_op = 2'd0; cmd_src = 3'd1; cmd_dst = 3'd3; cmd_valid = 1;
    @(posedge clk);
    #1 cmd_valid = 0;
    @(posedge clk);
    #2;
    chk("abort_latch_seen", 32'(reg_latch), 32'b1000);
    reset_n = 0;
    #1;
    chk("abort_enable", 32'(reg_enable), 0);
    chk("abort_latch", 32'(reg_latch), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_rd_data", 32'(rd_data), 0);
    @(posedge clk);
    #1 chk("abort_r3_kept", 32'(r[3]), 32'h99);
    @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    chk("abort_ready", 32'(cmd_ready), 1);
    chk("abort_no_done", 32'(done), 0);
    issue(2'd2, 3'd3, 3'd0, 8'h00);
    chk("abort_read_r3", 32'(rd_data), 32'h99);
    chk("abort_read_done", o_done, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
